// File: rtl/stdcell_vector_checker_if.sv
// Bus between the vector checker and its environment.
//   start       : request a new sweep
//   cut_in      : vector applied to the cell under test
//   cut_out     : cell output Y fed back to the checker
//   busy/done   : sweep in progress / sweep finished (held)
//   pass        : done with zero mismatches
//   err_count   : mismatching vectors this sweep (saturates at 2^N)
//   fail_index  : first failing vector, fail_actual its observed Y
interface stdcell_vector_checker_if #(
  parameter int unsigned NUM_INPUTS = 2
) ();
  logic                  start;
  logic [NUM_INPUTS-1:0] cut_in;
  logic                  cut_out;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [NUM_INPUTS:0]   err_count;
  logic [NUM_INPUTS-1:0] fail_index;
  logic                  fail_actual;

  // Environment side: issues start, closes the loop through the cell.
  modport master (
    output start, cut_out,
    input  cut_in, busy, done, pass, err_count, fail_index, fail_actual
  );

  // Checker side.
  modport slave (
    input  start, cut_out,
    output cut_in, busy, done, pass, err_count, fail_index, fail_actual
  );
endinterface

// File: rtl/stdcell_vector_checker.sv
// Exhaustive stimulus/check stage for a combinational standard cell.
// Steps cut_in through 0..2^N-1, holds each vector SETTLE_CYCLES cycles, then
// compares cut_out with TRUTH_TABLE[cut_in] and accumulates the results.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   vec   : slave side of stdcell_vector_checker_if (start, cut_in/out, results)
// All outputs are registered; cut_out and start only reach state registers.
module stdcell_vector_checker #(
  parameter int unsigned                  NUM_INPUTS    = 2,
  parameter logic [(1<<NUM_INPUTS)-1:0]   TRUTH_TABLE   = 4'b0111,
  parameter int unsigned                  SETTLE_CYCLES = 1,
  parameter bit                           STOP_ON_FAIL  = 1'b0
) (
  input logic                     clk,
  input logic                     reset,
  stdcell_vector_checker_if.slave vec
);

  localparam int unsigned NumVec = 1 << NUM_INPUTS;
  localparam int unsigned ErrW   = NUM_INPUTS + 1;
  localparam int unsigned CntW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [ErrW-1:0]       ErrMax     = ErrW'(NumVec);
  localparam logic [NUM_INPUTS-1:0] LastVec    = NUM_INPUTS'(NumVec - 1);
  localparam logic [CntW-1:0]       SettleLast = CntW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

  state_e                state_q;
  logic [NUM_INPUTS-1:0] cut_in_q;
  logic [CntW-1:0]       settle_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic [ErrW-1:0]       err_q;
  logic [NUM_INPUTS-1:0] fail_index_q;
  logic                  fail_actual_q;

  logic            mismatch;
  logic [ErrW-1:0] err_next;

  // Case-inequality so an X/Z cell output is reported as a failure in simulation.
  always_comb begin
    mismatch = (vec.cut_out !== TRUTH_TABLE[cut_in_q]);
    err_next = err_q;
    if (mismatch && (err_q != ErrMax)) begin
      err_next = err_q + ErrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cut_in_q      <= '0;
      settle_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= '0;
      fail_index_q  <= '0;
      fail_actual_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (vec.start) begin
            state_q       <= StDrive;
            cut_in_q      <= '0;
            settle_q      <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_q         <= '0;
            fail_index_q  <= '0;
            fail_actual_q <= 1'b0;
          end
        end
        StDrive: begin
          settle_q <= settle_q + CntW'(1);
          if (settle_q == SettleLast) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          err_q <= err_next;
          // err_q still zero means this is the first mismatch of the sweep.
          if (mismatch && (err_q == '0)) begin
            fail_index_q  <= cut_in_q;
            fail_actual_q <= vec.cut_out;
          end
          if ((cut_in_q == LastVec) || (STOP_ON_FAIL && mismatch)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_next == '0);
          end else begin
            state_q  <= StDrive;
            cut_in_q <= cut_in_q + NUM_INPUTS'(1);
            settle_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign vec.cut_in      = cut_in_q;
  assign vec.busy        = busy_q;
  assign vec.done        = done_q;
  assign vec.pass        = pass_q;
  assign vec.err_count   = err_q;
  assign vec.fail_index  = fail_index_q;
  assign vec.fail_actual = fail_actual_q;

endmodule
